// File: rtl/rtor_pipe.sv
// Purpose: valid/ready pipeline computing f = a | ~b per bit, as ~a then NAND(b), plus optional register stages.
// Latency: 2 + EXTRA_STAGES cycles from input handshake to out_valid when nothing stalls.
// Backpressure: combinational ready chain with no skid buffers; empty stages always fill, and full stages hold.
module rtor_pipe #(
    parameter int WIDTH        = 8,
    parameter int EXTRA_STAGES = 0,
    localparam int N           = 2 + EXTRA_STAGES,
    localparam int OW          = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [OW-1:0]    occupancy
);

    // Stage 1 holds ~a, and b1 travels beside it. Stage 2 onwards holds the result.
    logic [N:1]            vld;
    logic [N:1]            vld_nxt;
    logic [N:1]            rdy;
    logic [N:1][WIDTH-1:0] dat;
    logic [WIDTH-1:0]      b1;
    logic [OW-1:0]         occ_nxt;
    logic                  in_take;

    // A stage can take new content if the consumer takes, or if any stage at or below it is empty.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        rdy       = '0;
        for (int k = N; k >= 1; k--) begin
            full_tail = full_tail & vld[k];
            rdy[k]    = out_ready | ~full_tail;
        end
    end

    assign in_ready = ~rst & ~flush & rdy[1];
    assign in_take  = in_valid & in_ready;

    // Next valid bits: an advancing stage takes the upstream valid. Flush empties every stage.
    always_comb begin
        vld_nxt = vld;
        if (rdy[1]) begin
            vld_nxt[1] = in_take;
        end
        for (int k = 2; k <= N; k++) begin
            if (rdy[k]) begin
                vld_nxt[k] = vld[k-1];
            end
        end
        if (flush) begin
            vld_nxt = '0;
        end
    end

    // The occupancy register is loaded with the number of set next-state valid bits, so it follows vld exactly.
    always_comb begin
        occ_nxt = '0;
        for (int k = 1; k <= N; k++) begin
            occ_nxt = occ_nxt + OW'(vld_nxt[k]);
        end
    end

    // Stage registers: data moves only with a real item, and reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            dat       <= '0;
            b1        <= '0;
            occupancy <= '0;
        end else begin
            vld       <= vld_nxt;
            occupancy <= occ_nxt;
            if (in_take) begin
                dat[1] <= ~a;
                b1     <= b;
            end
            if (rdy[2] && vld[1] && !flush) begin
                dat[2] <= ~(dat[1] & b1);
            end
            for (int k = 3; k <= N; k++) begin
                if (rdy[k] && vld[k-1] && !flush) begin
                    dat[k] <= dat[k-1];
                end
            end
        end
    end

    assign f         = dat[N];
    assign out_valid = vld[N];

endmodule

// File: tb/tb_rtor_pipe.sv
// Bench for rtor_pipe using three instances: 8-bit N=2, 8-bit N=4 and 16-bit N=5.
// Inputs are driven 1 time unit after the rising edge, and outputs are checked on the falling edge.
// The random part of the bench tracks expected results in a queue and counts the items in flight.
module tb_rtor_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance s0: WIDTH=8, EXTRA_STAGES=0 (N=2)
    logic       s0_flush = 0, s0_in_valid = 0, s0_in_ready, s0_out_valid, s0_out_ready = 1;
    logic [7:0] s0_a = 0, s0_b = 0, s0_f;
    logic [1:0] s0_occ;

    // Instance s2: WIDTH=8, EXTRA_STAGES=2 (N=4)
    logic       s2_flush = 0, s2_in_valid = 0, s2_in_ready, s2_out_valid, s2_out_ready = 1;
    logic [7:0] s2_a = 0, s2_b = 0, s2_f;
    logic [2:0] s2_occ;

    // Instance s3: WIDTH=16, EXTRA_STAGES=3 (N=5)
    logic        s3_flush = 0, s3_in_valid = 0, s3_in_ready, s3_out_valid, s3_out_ready = 1;
    logic [15:0] s3_a = 0, s3_b = 0, s3_f;
    logic [2:0]  s3_occ;

    rtor_pipe #(.WIDTH(8), .EXTRA_STAGES(0)) u_s0 (
        .clk(clk), .rst(rst), .flush(s0_flush), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .a(s0_a), .b(s0_b), .out_valid(s0_out_valid), .out_ready(s0_out_ready), .f(s0_f),
        .occupancy(s0_occ)
    );

    rtor_pipe #(.WIDTH(8), .EXTRA_STAGES(2)) u_s2 (
        .clk(clk), .rst(rst), .flush(s2_flush), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
        .a(s2_a), .b(s2_b), .out_valid(s2_out_valid), .out_ready(s2_out_ready), .f(s2_f),
        .occupancy(s2_occ)
    );

    rtor_pipe #(.WIDTH(16), .EXTRA_STAGES(3)) u_s3 (
        .clk(clk), .rst(rst), .flush(s3_flush), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
        .a(s3_a), .b(s3_b), .out_valid(s3_out_valid), .out_ready(s3_out_ready), .f(s3_f),
        .occupancy(s3_occ)
    );

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++; if (s0_out_valid !== 1'b0) begin bad++; $display("FAIL reset_s0_out_valid got=%b exp=0", s0_out_valid); end
        total++; if (s0_f !== 8'h00) begin bad++; $display("FAIL reset_s0_f got=%h exp=00", s0_f); end
        total++; if (s0_occ !== 2'd0) begin bad++; $display("FAIL reset_s0_occ got=%0d exp=0", s0_occ); end
        total++; if (s0_in_ready !== 1'b0) begin bad++; $display("FAIL reset_s0_in_ready got=%b exp=0", s0_in_ready); end
        total++; if (s2_out_valid !== 1'b0 || s2_occ !== 3'd0) begin bad++; $display("FAIL reset_s2 got vld=%b occ=%0d exp 0/0", s2_out_valid, s2_occ); end
        total++; if (s3_out_valid !== 1'b0 || s3_f !== 16'h0) begin bad++; $display("FAIL reset_s3 got vld=%b f=%h exp 0/0000", s3_out_valid, s3_f); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (s0_in_ready !== 1'b1 || s2_in_ready !== 1'b1 || s3_in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_in_ready got=%b%b%b exp=111", s0_in_ready, s2_in_ready, s3_in_ready);
        end
    endtask

    // A single beat is used: 3C | ~A5 = 3C | 5A = 7E, and it is expected two cycles later.
    task automatic test_single_beat();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            s0_out_ready = 1'b1;
            s0_in_valid  = (c == 0);
            s0_a         = 8'h3C;
            s0_b         = 8'hA5;
            @(negedge clk);
            if (c == 0) begin
                total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b exp=1", s0_in_ready); end
            end else begin
                total++; if (s0_out_valid !== (c == 2)) begin bad++; $display("FAIL single_out_valid c=%0d got=%b exp=%b", c, s0_out_valid, (c == 2)); end
                if (c == 2) begin
                    total++; if (s0_f !== 8'h7E) begin bad++; $display("FAIL single_f got=%h exp=7e", s0_f); end
                end
            end
        end
    endtask

    // There are 32 back-to-back beats. For beats 0-15 b equals a, so f is all ones. For beats 16-31 b equals ~a, so f equals a, which also checks order.
    task automatic test_back_to_back();
        logic [7:0] expv [32];
        for (int i = 0; i < 32; i++) expv[i] = (i < 16) ? 8'hFF : 8'(i);
        for (int c = 0; c < 36; c++) begin
            @(posedge clk); #1;
            s0_out_ready = 1'b1;
            s0_in_valid  = (c < 32);
            s0_a         = 8'(c);
            s0_b         = (c < 16) ? 8'(c) : ~8'(c);
            @(negedge clk);
            if (c < 32) begin
                total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, s0_in_ready); end
            end
            if (c >= 2 && c < 34) begin
                total++; if (s0_out_valid !== 1'b1 || s0_f !== expv[c-2]) begin
                    bad++; $display("FAIL b2b_out c=%0d got vld=%b f=%h exp vld=1 f=%h", c, s0_out_valid, s0_f, expv[c-2]);
                end
            end else if (c >= 34) begin
                total++; if (s0_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail c=%0d got vld=%b exp=0", c, s0_out_valid); end
            end
        end
    endtask

    // N=4 with out_ready low: the pipe fills to 4, then stalls with item 0 held. Item k has a={k,0}, b=F0, so f={k,F}.
    task automatic test_stall_drain();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            s2_out_ready = 1'b0;
            s2_in_valid  = 1'b1;
            s2_a         = {4'(c), 4'h0};
            s2_b         = 8'hF0;
            @(negedge clk);
            total++; if (s2_occ !== 3'((c < 4) ? c : 4)) begin bad++; $display("FAIL stall_occ c=%0d got=%0d exp=%0d", c, s2_occ, (c < 4) ? c : 4); end
            total++; if (s2_in_ready !== (c < 4)) begin bad++; $display("FAIL stall_in_ready c=%0d got=%b exp=%b", c, s2_in_ready, (c < 4)); end
            if (c >= 4) begin
                total++; if (s2_out_valid !== 1'b1 || s2_f !== 8'h0F) begin bad++; $display("FAIL stall_hold c=%0d got vld=%b f=%h exp 1/0f", c, s2_out_valid, s2_f); end
            end
        end
        for (int r = 0; r < 5; r++) begin
            @(posedge clk); #1;
            s2_in_valid  = 1'b0;
            s2_out_ready = 1'b1;
            @(negedge clk);
            total++; if (s2_occ !== 3'(4 - r)) begin bad++; $display("FAIL drain_occ r=%0d got=%0d exp=%0d", r, s2_occ, 4 - r); end
            if (r == 0) begin
                total++; if (s2_in_ready !== 1'b1) begin bad++; $display("FAIL full_shift_in_ready got=%b exp=1", s2_in_ready); end
            end
            if (r < 4) begin
                total++; if (s2_out_valid !== 1'b1 || s2_f !== {4'(r), 4'hF}) begin
                    bad++; $display("FAIL drain_out r=%0d got vld=%b f=%h exp vld=1 f=%h", r, s2_out_valid, s2_f, {4'(r), 4'hF});
                end
            end else begin
                total++; if (s2_out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got vld=%b exp=0", s2_out_valid); end
            end
        end
    endtask

    // Three items are loaded, then flush is asserted while in_valid is high. Nothing may be accepted or emitted afterwards.
    task automatic test_flush();
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            s2_in_valid  = (c <= 3);
            s2_flush     = (c == 3);
            s2_out_ready = (c >= 3);
            s2_a         = 8'h11 * 8'(c + 1);
            s2_b         = 8'h00;
            @(negedge clk);
            if (c == 3) begin
                total++; if (s2_occ !== 3'd3) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=3", s2_occ); end
                total++; if (s2_in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", s2_in_ready); end
            end else if (c == 4) begin
                total++; if (s2_occ !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", s2_occ); end
            end
            if (c >= 4) begin
                total++; if (s2_out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_out c=%0d got vld=%b exp=0", c, s2_out_valid); end
            end
        end
        s2_flush = 1'b0;
    endtask

    // Reset is asserted with two items in flight, each with f=FF. Then a fresh beat 00/FF must give f=00.
    task automatic test_midstream_reset();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            rst          = (c == 2);
            s0_in_valid  = (c < 2) || (c == 3);
            s0_out_ready = (c >= 3);
            s0_a         = (c == 0) ? 8'hAA : (c == 1) ? 8'h55 : 8'h00;
            s0_b         = (c < 2) ? 8'h00 : 8'hFF;
            @(negedge clk);
            if (c == 2) begin
                total++; if (s0_occ !== 2'd2) begin bad++; $display("FAIL rst_pre_occ got=%0d exp=2", s0_occ); end
                total++; if (s0_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", s0_in_ready); end
            end
            if (c == 3) begin
                total++; if (s0_out_valid !== 1'b0 || s0_f !== 8'h00 || s0_occ !== 2'd0) begin
                    bad++; $display("FAIL rst_clear got vld=%b f=%h occ=%0d exp 0/00/0", s0_out_valid, s0_f, s0_occ);
                end
            end
            if (c == 4 || c == 6) begin
                total++; if (s0_out_valid !== 1'b0) begin bad++; $display("FAIL rst_after_vld c=%0d got=%b exp=0", c, s0_out_valid); end
            end
            if (c == 5) begin
                total++; if (s0_out_valid !== 1'b1 || s0_f !== 8'h00) begin bad++; $display("FAIL rst_new_beat got vld=%b f=%h exp 1/00", s0_out_valid, s0_f); end
            end
        end
    endtask

    // Random valid/ready on the 16-bit N=5 instance. The bench checks result values, order, and occupancy against the number of items in flight.
    task automatic test_random();
        logic [15:0] q[$];
        int sent = 0, got = 0, inflight = 0, cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            s3_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            s3_out_ready = ($urandom_range(0, 2) != 0);
            s3_a         = 16'($urandom);
            s3_b         = 16'($urandom);
            @(negedge clk);
            cyc++;
            total++; if (s3_occ !== 3'(inflight)) begin bad++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", cyc, s3_occ, inflight); end
            if (s3_out_valid && s3_out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_spurious cyc=%0d got f=%h exp no output", cyc, s3_f);
                end else begin
                    if (s3_f !== q[0]) begin bad++; $display("FAIL rand_data item=%0d got=%h exp=%h", got, s3_f, q[0]); end
                    void'(q.pop_front());
                    inflight--;
                    got++;
                end
            end
            if (s3_in_valid && s3_in_ready) begin
                q.push_back(s3_a | ~s3_b);
                inflight++;
                sent++;
            end
        end
        total++; if (got != 1000) begin bad++; $display("FAIL rand_timeout got=%0d items exp=1000", got); end
        @(posedge clk); #1;
        s3_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_stall_drain();
        test_flush();
        test_midstream_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
